vme64x_csr_func_bridge: RTL and testbench
=========================================

Name: vme64x_csr_func_bridge

Overview:
- Simplified VME64x slave front-end for the SVEC node top level.
- Holds the CR/CSR configuration space: function ADERs, module-enable bit and user control bit.
- Decodes A24/A32 single accesses against the programmed function windows and forwards matching ones to a 32-bit Wishbone master port, where the node CPU CSR sits at offset 0x2C000 of function 1.
- Upstream VME pin handling and buffering are already decoded into a request-strobe bus; that logic is outside this block.

Parameters:
- g_FUNC1_MASK, 24'hF80000: A24 compare mask for function 1 (512 KB window).
- g_FUNC0_MASK, 32'hFF000000: A32 compare mask for function 0 (16 MB window).
- g_BOARD_ID, 32'h00000198: board ID returned from the CR ROM.
- g_WB_TIMEOUT, 255: Wishbone wait limit in clk_125m_i cycles (used only with WB_TIMEOUT_EN).

Ports:
- clk_125m_i in 1: system clock.
- rst_i in 1: synchronous, active-high reset.
- vme_req_i in 1: one-cycle access strobe; sampled only in IDLE.
- vme_write_i in 1: 1 = write.
- vme_am_i in 6: address modifier.
- vme_addr_i in 32: byte address (A24 uses bits 23:0).
- vme_data_i in 32: write data (D08 uses bits 7:0).
- vme_data_o out 32: read data, valid while vme_ack_o=1.
- vme_ack_o out 1: one-cycle completion pulse.
- vme_berr_o out 1: one-cycle bus-error pulse (replaces ack).
- wb_cyc_o out 1: Wishbone cycle.
- wb_stb_o out 1: Wishbone strobe.
- wb_we_o out 1: Wishbone write enable.
- wb_adr_o out 32: window byte offset.
- wb_sel_o out 4: byte selects, always 4'hF.
- wb_dat_o out 32: write data.
- wb_dat_i in 32: read data.
- wb_ack_i in 1: Wishbone ack.
- wb_err_i in 1: Wishbone error.
- module_enable_o out 1: BIT_SET bit 4 state.
- wb32_mode_o out 1: user control bit 0.

Behaviour:
- Reset values: all outputs 0; ADER0 and ADER1 = 32'h00000001 (XAM=1, disabled); enable bit 0; wb32 bit 0; FSM in IDLE.
- CR/CSR space:
  - Selected when vme_am_i=6'h2F; uses vme_addr_i[18:0]; D08 data on bits 7:0; always accessible, even when disabled.
  - ADER of function F (F=0,1) occupies byte addresses 0x7FF63+F*0x10 +0, +4, +8, +C, holding ADER bits [31:24], [23:16], [15:8], [7:0].
  - 0x7FF33: bit0 = wb32_mode, read/write.
  - 0x7FFFB BIT_SET: writing 1s sets bits; bit4 = module enable. Reads return the current bits.
  - 0x7FFF7 BIT_CLR: writing 1s clears bits.
  - CR ROM reads: 0x27/0x2B/0x2F return 0x08/0x00/0x30 (CERN ID); 0x33/0x37/0x3B/0x3F return g_BOARD_ID bytes MSB first.
  - Other CR/CSR addresses read 0 and ignore writes.
  - CSR accesses ack 2 cycles after vme_req_i.
- Function decode:
  - Active only when module_enable=1 and AM is not 0x2F.
  - A function matches when ADER[0]=0, ADER[7:2]==vme_am_i, and (addr & mask)==(ADER[31:8]<<8 & mask).
  - Function 1 compares addr[23:0]; function 0 compares the full 32 bits.
  - Both matching: function 0 wins.
  - No match, or module disabled: vme_berr_o pulses 2 cycles after request; no Wishbone cycle is issued.
- FSM states: IDLE -> (CSR | WB_REQ | ERR) -> DONE -> IDLE.
  - WB_REQ: assert cyc/stb/we; wb_adr_o = addr & ~mask; wb_dat_o = vme_data_i.
  - Hold the cycle until wb_ack_i or wb_err_i. On that cycle, deassert cyc/stb and latch wb_dat_i into vme_data_o.
  - Next cycle: vme_ack_o pulse on wb_ack_i, vme_berr_o pulse on wb_err_i.
  - ack and err arriving together: err wins.
  - vme_req_i outside IDLE is ignored.
  - rst_i mid-access aborts immediately: cyc low, no ack.
- vme_data_o holds its last value between accesses.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- Defined: a counter starts at WB_REQ entry. If no wb_ack_i/wb_err_i arrives within g_WB_TIMEOUT cycles, the FSM drops cyc/stb and pulses vme_berr_o.
- Undefined: the FSM waits indefinitely for ack or err.

Test Plan:
- After reset: CR/CSR read 0x7FF63 (AM 0x2F) -> 0x00; read 0x7FF6F -> 0x01; module_enable_o=0.
- Write func1 ADER bytes 0x00,0xC0,0x00,0xE4; func0 byte 0x7FF6F=0x01; 0x7FF33=1; 0x7FFFB=0x10 -> module_enable_o=1, wb32_mode_o=1; readback 0x7FF7F -> 0xE4.
- A24 D32 write, AM 0x39, addr 0xC2C000, data 0x12345678 -> wb_adr_o=0x2C000, wb_we_o=1, wb_dat_o=0x12345678; wb_ack_i after 3 cycles -> vme_ack_o pulse the next cycle.
- Read at 0xC2C004, wb_dat_i=0xDEADBEEF -> vme_data_o=0xDEADBEEF with vme_ack_o.
- AM 0x39 at 0xD00000 (no match), or any access after writing 0x10 to BIT_CLR 0x7FFF7 -> vme_berr_o pulse; wb_cyc_o stays 0.
- With WB_TIMEOUT_EN and g_WB_TIMEOUT=16: no wb_ack_i -> vme_berr_o after 16 cycles, wb_cyc_o deasserted.

Source files
------------

// File: rtl/vme64x_csr_func_bridge_if.sv
// ---------------------------------------------------------------------------
// vme64x_csr_func_bridge_if
//
// Groups the decoded VME request-strobe bus, the 32-bit Wishbone master port
// and the two configuration outputs of vme64x_csr_func_bridge.
//
// Modports:
//   slave  - the bridge: VME slave side, Wishbone master side, config outputs.
//   master - the environment driving VME requests and answering on Wishbone.
//
// Signals:
//   vme_req_i/write_i/am_i/addr_i/data_i  access request strobe and fields
//   vme_data_o/ack_o/berr_o               read data and completion pulses
//   wb_cyc_o/stb_o/we_o/adr_o/sel_o/dat_o Wishbone request
//   wb_dat_i/ack_i/err_i                  Wishbone response
//   module_enable_o, wb32_mode_o          CSR control bits
// ---------------------------------------------------------------------------
interface vme64x_csr_func_bridge_if;
  logic        vme_req_i;
  logic        vme_write_i;
  logic [5:0]  vme_am_i;
  logic [31:0] vme_addr_i;
  logic [31:0] vme_data_i;
  logic [31:0] vme_data_o;
  logic        vme_ack_o;
  logic        vme_berr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        module_enable_o;
  logic        wb32_mode_o;

  modport slave (
    input  vme_req_i, vme_write_i, vme_am_i, vme_addr_i, vme_data_i,
    output vme_data_o, vme_ack_o, vme_berr_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output module_enable_o, wb32_mode_o
  );

  modport master (
    output vme_req_i, vme_write_i, vme_am_i, vme_addr_i, vme_data_i,
    input  vme_data_o, vme_ack_o, vme_berr_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  module_enable_o, wb32_mode_o
  );
endinterface

// File: rtl/vme64x_csr_func_bridge.sv
// ---------------------------------------------------------------------------
// vme64x_csr_func_bridge
//
// Simplified VME64x slave front-end. Holds the CR/CSR space (function ADERs,
// module-enable bit, wb32 user bit, CR ROM ID bytes), decodes A24/A32 single
// accesses against the function windows and forwards hits to a 32-bit
// Wishbone master. Misses, or any function access while disabled, end in a
// one-cycle bus error.
//
// Ports:
//   clk_125m_i  system clock
//   rst_i       synchronous active-high reset
//   bus         vme64x_csr_func_bridge_if.slave (VME request bus, Wishbone
//               master, module_enable_o, wb32_mode_o)
//
// Build option:
//   WB_TIMEOUT_EN  when defined, a Wishbone cycle without ack/err for
//                  g_WB_TIMEOUT cycles is dropped and reported as bus error.
// ---------------------------------------------------------------------------
module vme64x_csr_func_bridge #(
  parameter logic [23:0] g_FUNC1_MASK = 24'hF80000,
  parameter logic [31:0] g_FUNC0_MASK = 32'hFF000000,
  parameter logic [31:0] g_BOARD_ID   = 32'h00000198,
  parameter int unsigned g_WB_TIMEOUT = 255
) (
  input logic                     clk_125m_i,
  input logic                     rst_i,
  vme64x_csr_func_bridge_if.slave bus
);

  localparam logic [5:0] AmCsr = 6'h2F;

  typedef enum logic [2:0] {StIdle, StCsr, StWbReq, StErr, StDone} state_e;

  state_e      state_q, state_d;
  logic [18:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        berr_q, berr_d;
  logic        cyc_q, cyc_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [31:0] ader0_q, ader0_d;
  logic [31:0] ader1_q, ader1_d;
  logic        enable_q, enable_d;
  logic        wb32_q, wb32_d;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(g_WB_TIMEOUT + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  logic       csr_sel, f0_hit, f1_hit;
  logic [7:0] csr_rd_byte;

  // Address decode of the live request; only consulted in StIdle.
  always_comb begin
    csr_sel = (bus.vme_am_i == AmCsr);
    f0_hit  = enable_q && !csr_sel && !ader0_q[0] && (ader0_q[7:2] == bus.vme_am_i) &&
              ((bus.vme_addr_i & g_FUNC0_MASK) == ({ader0_q[31:8], 8'h00} & g_FUNC0_MASK));
    f1_hit  = enable_q && !csr_sel && !ader1_q[0] && (ader1_q[7:2] == bus.vme_am_i) &&
              ((bus.vme_addr_i[23:0] & g_FUNC1_MASK) ==
               ({ader1_q[23:8], 8'h00} & g_FUNC1_MASK));
  end

  // CR/CSR read mux on the latched address (D08, byte lanes at offsets 3 mod 4).
  always_comb begin
    csr_rd_byte = 8'h00;
    case (addr_q)
      19'h7FF63:          csr_rd_byte = ader0_q[31:24];
      19'h7FF67:          csr_rd_byte = ader0_q[23:16];
      19'h7FF6B:          csr_rd_byte = ader0_q[15:8];
      19'h7FF6F:          csr_rd_byte = ader0_q[7:0];
      19'h7FF73:          csr_rd_byte = ader1_q[31:24];
      19'h7FF77:          csr_rd_byte = ader1_q[23:16];
      19'h7FF7B:          csr_rd_byte = ader1_q[15:8];
      19'h7FF7F:          csr_rd_byte = ader1_q[7:0];
      19'h7FF33:          csr_rd_byte = {7'h00, wb32_q};
      19'h7FFFB, 19'h7FFF7: csr_rd_byte = {3'b000, enable_q, 4'h0};
      19'h00027:          csr_rd_byte = 8'h08;
      19'h0002B:          csr_rd_byte = 8'h00;
      19'h0002F:          csr_rd_byte = 8'h30;
      19'h00033:          csr_rd_byte = g_BOARD_ID[31:24];
      19'h00037:          csr_rd_byte = g_BOARD_ID[23:16];
      19'h0003B:          csr_rd_byte = g_BOARD_ID[15:8];
      19'h0003F:          csr_rd_byte = g_BOARD_ID[7:0];
      default:            csr_rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    berr_d   = 1'b0;
    cyc_d    = cyc_q;
    wb_we_d  = wb_we_q;
    wb_adr_d = wb_adr_q;
    wb_dat_d = wb_dat_q;
    ader0_d  = ader0_q;
    ader1_d  = ader1_q;
    enable_d = enable_q;
    wb32_d   = wb32_q;
`ifdef WB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.vme_req_i) begin
          addr_d  = bus.vme_addr_i[18:0];
          we_d    = bus.vme_write_i;
          wdata_d = bus.vme_data_i[7:0];
`ifdef WB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          if (csr_sel) begin
            state_d = StCsr;
          end else if (f0_hit) begin
            // Function 0 has priority when both windows match.
            state_d  = StWbReq;
            cyc_d    = 1'b1;
            wb_we_d  = bus.vme_write_i;
            wb_adr_d = bus.vme_addr_i & ~g_FUNC0_MASK;
            wb_dat_d = bus.vme_data_i;
          end else if (f1_hit) begin
            state_d  = StWbReq;
            cyc_d    = 1'b1;
            wb_we_d  = bus.vme_write_i;
            wb_adr_d = {8'h00, bus.vme_addr_i[23:0] & ~g_FUNC1_MASK};
            wb_dat_d = bus.vme_data_i;
          end else begin
            state_d = StErr;
          end
        end
      end

      StCsr: begin
        ack_d   = 1'b1;
        state_d = StDone;
        if (we_q) begin
          case (addr_q)
            19'h7FF63: ader0_d[31:24] = wdata_q;
            19'h7FF67: ader0_d[23:16] = wdata_q;
            19'h7FF6B: ader0_d[15:8]  = wdata_q;
            19'h7FF6F: ader0_d[7:0]   = wdata_q;
            19'h7FF73: ader1_d[31:24] = wdata_q;
            19'h7FF77: ader1_d[23:16] = wdata_q;
            19'h7FF7B: ader1_d[15:8]  = wdata_q;
            19'h7FF7F: ader1_d[7:0]   = wdata_q;
            19'h7FF33: wb32_d         = wdata_q[0];
            19'h7FFFB: if (wdata_q[4]) enable_d = 1'b1;
            19'h7FFF7: if (wdata_q[4]) enable_d = 1'b0;
            default: ;
          endcase
        end else begin
          rdata_d = {24'h000000, csr_rd_byte};
        end
      end

      StErr: begin
        berr_d  = 1'b1;
        state_d = StDone;
      end

      StWbReq: begin
        if (bus.wb_ack_i || bus.wb_err_i) begin
          // Error wins over a simultaneous ack.
          cyc_d   = 1'b0;
          wb_we_d = 1'b0;
          rdata_d = bus.wb_dat_i;
          ack_d   = !bus.wb_err_i;
          berr_d  = bus.wb_err_i;
          state_d = StDone;
`ifdef WB_TIMEOUT_EN
        end else if (tmo_cnt_q == TmoW'(g_WB_TIMEOUT - 1)) begin
          cyc_d   = 1'b0;
          wb_we_d = 1'b0;
          berr_d  = 1'b1;
          state_d = StDone;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_125m_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      berr_q   <= 1'b0;
      cyc_q    <= 1'b0;
      wb_we_q  <= 1'b0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      ader0_q  <= 32'h00000001;
      ader1_q  <= 32'h00000001;
      enable_q <= 1'b0;
      wb32_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      berr_q   <= berr_d;
      cyc_q    <= cyc_d;
      wb_we_q  <= wb_we_d;
      wb_adr_q <= wb_adr_d;
      wb_dat_q <= wb_dat_d;
      ader0_q  <= ader0_d;
      ader1_q  <= ader1_d;
      enable_q <= enable_d;
      wb32_q   <= wb32_d;
`ifdef WB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign bus.vme_data_o      = rdata_q;
  assign bus.vme_ack_o       = ack_q;
  assign bus.vme_berr_o      = berr_q;
  assign bus.wb_cyc_o        = cyc_q;
  assign bus.wb_stb_o        = cyc_q;
  assign bus.wb_we_o         = wb_we_q;
  assign bus.wb_adr_o        = wb_adr_q;
  assign bus.wb_sel_o        = {4{cyc_q}};
  assign bus.wb_dat_o        = wb_dat_q;
  assign bus.module_enable_o = enable_q;
  assign bus.wb32_mode_o     = wb32_q;

endmodule

// File: tb/tb_vme64x_csr_func_bridge.sv
// ---------------------------------------------------------------------------
// tb_vme64x_csr_func_bridge
//
// Directed and randomized accesses against vme64x_csr_func_bridge. Expected
// outcomes come from a register-map model of the CR/CSR space and a window
// match computed with plain mask arithmetic. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_vme64x_csr_func_bridge;

  localparam logic [31:0] BoardId = 32'h00000198;
  localparam logic [31:0] M0      = 32'hFF000000;
  localparam logic [31:0] M1      = 32'h00F80000;
  localparam int          Tmo     = 16;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  vme64x_csr_func_bridge_if bus ();

  vme64x_csr_func_bridge #(.g_WB_TIMEOUT(Tmo)) dut (
    .clk_125m_i(clk),
    .rst_i     (rst),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_ader [2];
  logic        m_en, m_wb32;
  logic [31:0] m_rdata;

  logic [18:0] csr_wr_list [11] = '{19'h7FF63, 19'h7FF67, 19'h7FF6B, 19'h7FF6F, 19'h7FF73,
                                    19'h7FF77, 19'h7FF7B, 19'h7FF7F, 19'h7FF33, 19'h7FFFB,
                                    19'h7FFF7};
  logic [18:0] csr_rd_list [14] = '{19'h7FF63, 19'h7FF6F, 19'h7FF73, 19'h7FF7F, 19'h7FF33,
                                    19'h7FFFB, 19'h00027, 19'h0002B, 19'h0002F, 19'h00033,
                                    19'h00037, 19'h0003B, 19'h0003F, 19'h12345};
  logic [7:0]  ader_lo_list [5] = '{8'hE4, 8'h24, 8'hE5, 8'hF4, 8'h01};

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ader[0] = 32'h00000001;
    m_ader[1] = 32'h00000001;
    m_en      = 1'b0;
    m_wb32    = 1'b0;
    m_rdata   = 32'h0;
  endtask

  function automatic logic [7:0] m_csr_read(input logic [18:0] a);
    int ia = int'(a);
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 4; b++)
        if (ia == 'h7FF63 + f * 'h10 + b * 4) return 8'(m_ader[f] >> (24 - 8 * b));
    if (ia == 'h7FF33) return {7'h00, m_wb32};
    if (ia == 'h7FFFB || ia == 'h7FFF7) return m_en ? 8'h10 : 8'h00;
    if (ia == 'h27) return 8'h08;
    if (ia == 'h2B) return 8'h00;
    if (ia == 'h2F) return 8'h30;
    for (int b = 0; b < 4; b++)
      if (ia == 'h33 + b * 4) return 8'(BoardId >> (24 - 8 * b));
    return 8'h00;
  endfunction

  task automatic m_csr_write(input logic [18:0] a, input logic [7:0] d);
    int ia = int'(a);
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 4; b++)
        if (ia == 'h7FF63 + f * 'h10 + b * 4) m_ader[f][(24 - 8 * b) +: 8] = d;
    if (ia == 'h7FF33) m_wb32 = d[0];
    if (ia == 'h7FFFB && d[4]) m_en = 1'b1;
    if (ia == 'h7FFF7 && d[4]) m_en = 1'b0;
  endtask

  // Returns the matching function (0 preferred) or -1; adr gets the window offset.
  function automatic int m_decode(input logic [5:0] am, input logic [31:0] a,
                                  output logic [31:0] adr);
    adr = 32'h0;
    if (!m_en || am == 6'h2F) return -1;
    if (!m_ader[0][0] && m_ader[0][7:2] == am &&
        (a & M0) == (m_ader[0] & 32'hFFFFFF00 & M0)) begin
      adr = a & ~M0;
      return 0;
    end
    if (!m_ader[1][0] && m_ader[1][7:2] == am &&
        (a & 32'h00FFFFFF & M1) == (m_ader[1] & 32'hFFFFFF00 & M1)) begin
      adr = a & 32'h00FFFFFF & ~M1;
      return 1;
    end
    return -1;
  endfunction

  // One access: resp 0=ack, 1=err, 2=ack+err, 3=no response.
  // poke re-asserts a request (a BIT_CLR write) while the access is in flight.
  task automatic xfer(input string tag, input logic wr, input logic [5:0] am,
                      input logic [31:0] addr, input logic [31:0] wdata, input int ack_dly,
                      input int resp, input logic [31:0] rsp_dat, input logic poke);
    int f, e_lat, e_cyc, lat, n_cyc;
    logic e_ack, e_berr, g_ack, g_berr, g_cyc_end, done, quiet, c_we;
    logic [31:0] e_adr, e_dat, g_dat, c_adr, c_dat;
    logic [3:0] c_sel;
    f = -1; e_adr = 0; lat = 0; n_cyc = 0; g_ack = 0; g_berr = 0; g_cyc_end = 0;
    g_dat = 0; c_adr = 0; c_dat = 0; c_we = 0; c_sel = 0; done = 0; quiet = 1;
    if (am == 6'h2F) begin
      e_ack = 1; e_berr = 0; e_lat = 2; e_cyc = 0;
      e_dat = wr ? m_rdata : {24'h0, m_csr_read(addr[18:0])};
    end else begin
      f = m_decode(am, addr, e_adr);
      if (f < 0) begin
        e_ack = 0; e_berr = 1; e_lat = 2; e_cyc = 0; e_dat = m_rdata;
      end else if (resp == 3) begin
        e_ack = 0; e_berr = 1; e_lat = Tmo + 1; e_cyc = Tmo; e_dat = m_rdata;
      end else begin
        e_ack = (resp == 0); e_berr = (resp != 0); e_lat = ack_dly + 1; e_cyc = ack_dly;
        e_dat = rsp_dat;
      end
    end

    @(negedge clk);
    bus.vme_req_i   = 1'b1;
    bus.vme_write_i = wr;
    bus.vme_am_i    = am;
    bus.vme_addr_i  = addr;
    bus.vme_data_i  = wdata;
    for (int k = 1; k <= Tmo + 40; k++) begin
      @(negedge clk);
      bus.vme_req_i = 1'b0;
      bus.wb_ack_i  = 1'b0;
      bus.wb_err_i  = 1'b0;
      if (poke && k == 1) begin
        bus.vme_req_i   = 1'b1;
        bus.vme_write_i = 1'b1;
        bus.vme_am_i    = 6'h2F;
        bus.vme_addr_i  = 32'h0007FFF7;
        bus.vme_data_i  = 32'h10;
      end
      if (bus.vme_ack_o || bus.vme_berr_o) begin
        lat = k; g_ack = bus.vme_ack_o; g_berr = bus.vme_berr_o;
        g_dat = bus.vme_data_o; g_cyc_end = bus.wb_cyc_o; done = 1;
        break;
      end
      if (bus.wb_cyc_o) begin
        n_cyc++;
        c_adr = bus.wb_adr_o; c_we = bus.wb_we_o; c_dat = bus.wb_dat_o; c_sel = bus.wb_sel_o;
        if (n_cyc == ack_dly && resp != 3) begin
          bus.wb_ack_i = (resp != 1);
          bus.wb_err_i = (resp != 0);
          bus.wb_dat_i = rsp_dat;
        end
      end
    end
    bus.vme_req_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.vme_ack_o || bus.vme_berr_o || bus.wb_cyc_o) quiet = 0;
    end

    if (am == 6'h2F && wr) m_csr_write(addr[18:0], wdata[7:0]);
    m_rdata = e_dat;

    check32({tag, ".done"}, 32'(done), 32'd1);
    check32({tag, ".ack"}, 32'(g_ack), 32'(e_ack));
    check32({tag, ".berr"}, 32'(g_berr), 32'(e_berr));
    check32({tag, ".lat"}, 32'(lat), 32'(e_lat));
    check32({tag, ".ncyc"}, 32'(n_cyc), 32'(e_cyc));
    check32({tag, ".data"}, g_dat, e_dat);
    check32({tag, ".cyc_end"}, 32'(g_cyc_end), 32'd0);
    check32({tag, ".quiet"}, 32'(quiet), 32'd1);
    check32({tag, ".en"}, 32'(bus.module_enable_o), 32'(m_en));
    check32({tag, ".wb32"}, 32'(bus.wb32_mode_o), 32'(m_wb32));
    if (e_cyc > 0) begin
      check32({tag, ".adr"}, c_adr, e_adr);
      check32({tag, ".we"}, 32'(c_we), 32'(wr));
      check32({tag, ".wdat"}, c_dat, wdata);
      check32({tag, ".sel"}, 32'(c_sel), 32'hF);
    end
  endtask

  task automatic csr_wr(input string tag, input logic [18:0] a, input logic [7:0] d);
    xfer(tag, 1'b1, 6'h2F, {13'h0, a}, {24'h0, d}, 1, 0, 32'h0, 1'b0);
  endtask

  task automatic csr_rd(input string tag, input logic [18:0] a);
    xfer(tag, 1'b0, 6'h2F, {13'h0, a}, 32'h0, 1, 0, 32'h0, 1'b0);
  endtask

  initial begin
    int op, ws;
    logic [31:0] a, d;
    logic [5:0] am;
    logic [7:0] b;

    rst = 1'b1;
    bus.vme_req_i = 0; bus.vme_write_i = 0; bus.vme_am_i = 0; bus.vme_addr_i = 0;
    bus.vme_data_i = 0; bus.wb_dat_i = 0; bus.wb_ack_i = 0; bus.wb_err_i = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check32("rst.ack", 32'(bus.vme_ack_o), 32'd0);
    check32("rst.berr", 32'(bus.vme_berr_o), 32'd0);
    check32("rst.cyc", 32'(bus.wb_cyc_o), 32'd0);
    check32("rst.data", bus.vme_data_o, 32'd0);
    check32("rst.en", 32'(bus.module_enable_o), 32'd0);
    check32("rst.wb32", 32'(bus.wb32_mode_o), 32'd0);
    rst = 1'b0;

    csr_rd("rd_ader0_b0", 19'h7FF63);
    check32("rd_ader0_b0.lit", bus.vme_data_o, 32'h00);
    csr_rd("rd_ader0_b3", 19'h7FF6F);
    check32("rd_ader0_b3.lit", bus.vme_data_o, 32'h01);
    xfer("dis_acc", 1'b0, 6'h39, 32'h00C2C000, 32'h0, 1, 0, 32'h0, 1'b0);

    csr_wr("w_a1b0", 19'h7FF73, 8'h00);
    csr_wr("w_a1b1", 19'h7FF77, 8'hC0);
    csr_wr("w_a1b2", 19'h7FF7B, 8'h00);
    csr_wr("w_a1b3", 19'h7FF7F, 8'hE4);
    csr_wr("w_a0b3", 19'h7FF6F, 8'h01);
    csr_wr("w_wb32", 19'h7FF33, 8'h01);
    csr_wr("w_bset", 19'h7FFFB, 8'h10);
    check32("en_lit", 32'(bus.module_enable_o), 32'd1);
    csr_rd("rd_a1b3", 19'h7FF7F);
    check32("rd_a1b3.lit", bus.vme_data_o, 32'hE4);
    for (int i = 0; i < 7; i++) csr_rd("rd_rom", csr_rd_list[6 + i]);

    xfer("a24_wr", 1'b1, 6'h39, 32'h00C2C000, 32'h12345678, 3, 0, 32'h0BAD0BAD, 1'b0);
    xfer("a24_rd", 1'b0, 6'h39, 32'h00C2C004, 32'h0, 2, 0, 32'hDEADBEEF, 1'b0);
    check32("a24_rd.lit", bus.vme_data_o, 32'hDEADBEEF);
    xfer("a24_err", 1'b0, 6'h39, 32'h00C00010, 32'h0, 1, 1, 32'hCAFEF00D, 1'b0);
    xfer("a24_both", 1'b1, 6'h39, 32'h00C7FFFC, 32'hA5A5A5A5, 2, 2, 32'h5A5A5A5A, 1'b0);
    xfer("a24_hold", 1'b0, 6'h39, 32'h00C40000, 32'h0, 10, 0, 32'h13579BDF, 1'b0);
    xfer("nomatch", 1'b0, 6'h39, 32'h00D00000, 32'h0, 1, 0, 32'h0, 1'b0);
    xfer("wrong_am", 1'b0, 6'h3D, 32'h00C2C000, 32'h0, 1, 0, 32'h0, 1'b0);
    xfer("poke", 1'b0, 6'h39, 32'h00C2C008, 32'h0, 3, 0, 32'h11223344, 1'b1);

    // Function 0 on A32, then overlapping both windows with the same AM.
    csr_wr("w_a0b0", 19'h7FF63, 8'h42);
    csr_wr("w_a0b3", 19'h7FF6F, 8'h24);
    xfer("a32_rd", 1'b0, 6'h09, 32'h42123450, 32'h0, 1, 0, 32'h87654321, 1'b0);
    csr_wr("w_a0b0z", 19'h7FF63, 8'h00);
    csr_wr("w_a0b3e", 19'h7FF6F, 8'hE4);
    xfer("overlap", 1'b1, 6'h39, 32'h00C2C000, 32'hFEEDFACE, 1, 0, 32'h0, 1'b0);
    csr_wr("w_a0b0r", 19'h7FF63, 8'h42);
    csr_wr("w_a0b3r", 19'h7FF6F, 8'h24);

    for (int i = 0; i < 150; i++) begin
      if (i % 25 == 0) csr_wr("rnd_bset", 19'h7FFFB, 8'h10);
      op = $urandom_range(0, 9);
      if (op == 0) begin
        a = {13'h0, csr_wr_list[$urandom_range(0, 10)]};
        b = 8'($urandom);
        if (a == 32'h7FF6F || a == 32'h7FF7F) b = ader_lo_list[$urandom_range(0, 4)];
        csr_wr("rnd_cw", a[18:0], b);
      end else if (op == 1) begin
        csr_rd("rnd_cr", csr_rd_list[$urandom_range(0, 13)]);
      end else begin
        ws = $urandom_range(0, 2);
        d  = $urandom;
        if (ws == 0) a = {8'($urandom), m_ader[1][23:19], 19'($urandom)};
        else if (ws == 1) a = {m_ader[0][31:24], 24'($urandom)};
        else a = $urandom;
        op = $urandom_range(0, 4);
        if (op == 0) am = m_ader[0][7:2];
        else if (op == 1) am = m_ader[1][7:2];
        else if (op == 2) am = 6'h39;
        else if (op == 3) am = 6'h09;
        else am = 6'($urandom);
        op = $urandom_range(0, 7);
        xfer("rnd_fn", 1'($urandom), am, a, d, $urandom_range(1, 4),
             (op < 6) ? 0 : op - 5, $urandom, 1'b0);
      end
    end

    // Restore a known map, then disable through BIT_CLR.
    csr_wr("fix_a1b1", 19'h7FF77, 8'hC0);
    csr_wr("fix_a1b3", 19'h7FF7F, 8'hE4);
    csr_wr("fix_bset", 19'h7FFFB, 8'h10);
    xfer("fix_acc", 1'b0, 6'h39, 32'h00C2C000, 32'h0, 1, 0, 32'h31415926, 1'b0);
`ifdef WB_TIMEOUT_EN
    xfer("tmo", 1'b0, 6'h39, 32'h00C2C000, 32'h0, 1, 3, 32'h0, 1'b0);
`endif
    csr_wr("bclr", 19'h7FFF7, 8'h10);
    check32("bclr.lit", 32'(bus.module_enable_o), 32'd0);
    xfer("dis_acc2", 1'b1, 6'h39, 32'h00C2C000, 32'h1, 1, 0, 32'h0, 1'b0);

    // Reset in the middle of a Wishbone cycle.
    csr_wr("mr_bset", 19'h7FFFB, 8'h10);
    @(negedge clk);
    bus.vme_req_i = 1'b1; bus.vme_write_i = 1'b0; bus.vme_am_i = 6'h39;
    bus.vme_addr_i = 32'h00C2C000;
    @(negedge clk);
    bus.vme_req_i = 1'b0;
    check32("mr.cyc_on", 32'(bus.wb_cyc_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    check32("mr.cyc_off", 32'(bus.wb_cyc_o), 32'd0);
    check32("mr.en", 32'(bus.module_enable_o), 32'd0);
    bus.wb_ack_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check32("mr.noack", 32'(bus.vme_ack_o | bus.vme_berr_o | bus.wb_cyc_o), 32'd0);
    end
    bus.wb_ack_i = 1'b0;
    csr_rd("mr_rd", 19'h7FF6F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
